// File: rtl/fht_but_core.sv
// Radix-2 Fast Hartley Transform butterfly: Y0 = X0 + T, Y1 = X0 - T with
// T = round(X1*cos + X2*sin), saturated and registered with one cycle of latency.
module fht_but_core #(
  parameter int D_BIT  = 17,
  parameter int W_BIT  = 12,
  parameter int W_HALF = 512
) (
  input  logic               iCLK,
  input  logic               iRESET,
  input  logic [D_BIT-1:0]   iX_0,
  input  logic [D_BIT-1:0]   iX_1,
  input  logic [D_BIT-1:0]   iX_2,
  input  logic [W_BIT-1:0]   iSIN,
  input  logic [W_BIT-1:0]   iCOS,
  output logic [D_BIT-1:0]   oY_0,
  output logic [D_BIT-1:0]   oY_1
);

  localparam int SH    = $clog2(W_HALF) + 1;
  localparam int P_BIT = D_BIT + W_BIT + 1;

  localparam logic signed [P_BIT-1:0] RND_C  = P_BIT'(W_HALF);
  localparam logic signed [P_BIT-1:0] SAT_HI = P_BIT'((64'sd1 <<< (D_BIT - 1)) - 64'sd1);
  localparam logic signed [P_BIT-1:0] SAT_LO = ~SAT_HI;

  // Clamp a wide signed sum into the signed D_BIT output range.
  function automatic logic [D_BIT-1:0] sat_f(input logic signed [P_BIT-1:0] v);
    logic [D_BIT-1:0] r;
    if (v > SAT_HI) begin
      r = SAT_HI[D_BIT-1:0];
    end else if (v < SAT_LO) begin
      r = SAT_LO[D_BIT-1:0];
    end else begin
      r = v[D_BIT-1:0];
    end
    return r;
  endfunction

  logic signed [P_BIT-1:0] x0_ext_s;
  logic signed [P_BIT-1:0] x1_ext_s;
  logic signed [P_BIT-1:0] x2_ext_s;
  logic signed [P_BIT-1:0] cos_ext_s;
  logic signed [P_BIT-1:0] sin_ext_s;
  logic signed [P_BIT-1:0] prod_s;
  logic signed [P_BIT-1:0] rnd_s;
  logic signed [P_BIT-1:0] t_s;
  logic signed [P_BIT-1:0] sum0_s;
  logic signed [P_BIT-1:0] sum1_s;
  logic [D_BIT-1:0]        y0_r;
  logic [D_BIT-1:0]        y1_r;

  // Rotation, round-half-up and the two butterfly sums. Sums stay at full
  // product width so they can never wrap before saturation.
  always_comb begin
    x0_ext_s  = {{(P_BIT-D_BIT){iX_0[D_BIT-1]}}, iX_0};
    x1_ext_s  = {{(P_BIT-D_BIT){iX_1[D_BIT-1]}}, iX_1};
    x2_ext_s  = {{(P_BIT-D_BIT){iX_2[D_BIT-1]}}, iX_2};
    cos_ext_s = {{(P_BIT-W_BIT){iCOS[W_BIT-1]}}, iCOS};
    sin_ext_s = {{(P_BIT-W_BIT){iSIN[W_BIT-1]}}, iSIN};
    prod_s    = x1_ext_s * cos_ext_s + x2_ext_s * sin_ext_s;
    rnd_s     = prod_s + RND_C;
    t_s       = rnd_s >>> SH;
    sum0_s    = x0_ext_s + t_s;
    sum1_s    = x0_ext_s - t_s;
  end

  // Output registers with synchronous reset.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      y0_r <= {D_BIT{1'b0}};
      y1_r <= {D_BIT{1'b0}};
    end else begin
      y0_r <= sat_f(sum0_s);
      y1_r <= sat_f(sum1_s);
    end
  end

  assign oY_0 = y0_r;
  assign oY_1 = y1_r;

endmodule

// File: tb/tb_fht_but_core.sv
// Directed and streaming checks for fht_but_core against hand-computed values
// and a behavioural golden model.
module tb_fht_but_core;

  logic               clk;
  logic               rst;
  logic signed [16:0] x0_i, x1_i, x2_i;
  logic signed [11:0] sin_i, cos_i;
  logic signed [16:0] y0_o, y1_o;

  int n_cmp;
  int n_bad;

  fht_but_core dut (
    .iCLK   (clk),
    .iRESET (rst),
    .iX_0   (x0_i),
    .iX_1   (x1_i),
    .iX_2   (x2_i),
    .iSIN   (sin_i),
    .iCOS   (cos_i),
    .oY_0   (y0_o),
    .oY_1   (y1_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input int x0, input int x1, input int x2, input int c, input int s);
    x0_i  = x0[16:0];
    x1_i  = x1[16:0];
    x2_i  = x2[16:0];
    cos_i = c[11:0];
    sin_i = s[11:0];
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input longint v);
    if (v > 65535) return 65535;
    if (v < -65536) return -65536;
    return int'(v);
  endfunction

  task automatic model(input int x0, input int x1, input int x2, input int c, input int s,
                       output int y0, output int y1);
    longint p, t;
    p  = longint'(x1) * c + longint'(x2) * s;
    t  = (p + 512) >>> 10;
    y0 = clamp(longint'(x0) + t);
    y1 = clamp(longint'(x0) - t);
  endtask

  initial begin
    int e0, e1, p0, p1;
    int rx0, rx1, rx2, rc, rs;
    real ang;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    drive(123, 456, 789, 1024, 0);
    @(negedge clk);
    @(negedge clk);
    check("reset_y0", y0_o, 0);
    check("reset_y1", y1_o, 0);

    rst = 1'b0;
    drive(100, 50, 7, 1024, 0);
    @(negedge clk);
    check("ident_y0", y0_o, 150);
    check("ident_y1", y1_o, 50);

    drive(-200, 999, 300, 0, 1024);
    @(negedge clk);
    check("sinp_y0", y0_o, 100);
    check("sinp_y1", y1_o, -500);

    drive(-200, 999, 300, 0, -1024);
    @(negedge clk);
    check("sinn_y0", y0_o, -500);
    check("sinn_y1", y1_o, 100);

    drive(0, 3, 0, 512, 0);
    @(negedge clk);
    check("rnd_pos_y0", y0_o, 2);
    check("rnd_pos_y1", y1_o, -2);

    drive(0, -3, 0, 512, 0);
    @(negedge clk);
    check("rnd_neg_y0", y0_o, -1);
    check("rnd_neg_y1", y1_o, 1);

    drive(0, 1, 0, 511, 0);
    @(negedge clk);
    check("rnd_zero_y0", y0_o, 0);
    check("rnd_zero_y1", y1_o, 0);

    drive(65535, 1000, 0, 1024, 0);
    @(negedge clk);
    check("sat_hi_y0", y0_o, 65535);
    check("sat_hi_y1", y1_o, 64535);

    drive(-65536, 1000, 0, 1024, 0);
    @(negedge clk);
    check("sat_lo_y0", y0_o, -64536);
    check("sat_lo_y1", y1_o, -65536);

    // Back-to-back random stream, each result checked one cycle later.
    for (int i = 0; i <= 30; i++) begin
      if (i > 0) begin
        check("stream_y0", y0_o, p0);
        check("stream_y1", y1_o, p1);
      end
      if (i < 30) begin
        rx0 = int'($urandom_range(65534, 0)) - 32767;
        rx1 = int'($urandom_range(65534, 0)) - 32767;
        rx2 = int'($urandom_range(65534, 0)) - 32767;
        ang = real'($urandom_range(3599, 0)) * 3.14159265358979 / 1800.0;
        rc  = $rtoi($floor(1024.0 * $cos(ang) + 0.5));
        rs  = $rtoi($floor(1024.0 * $sin(ang) + 0.5));
        drive(rx0, rx1, rx2, rc, rs);
        model(rx0, rx1, rx2, rc, rs, p0, p1);
        @(negedge clk);
      end
    end

    // Reset in the middle of a stream discards the captured vector.
    drive(20000, 3000, -4000, 724, 724);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_y0", y0_o, 0);
    check("midrst_y1", y1_o, 0);

    rst = 1'b0;
    drive(-1234, 5678, -910, -724, 724);
    model(-1234, 5678, -910, -724, 724, e0, e1);
    @(negedge clk);
    check("resume_y0", y0_o, e0);
    check("resume_y1", y1_o, e1);

    drive(500, -20000, 15000, 887, -512);
    model(500, -20000, 15000, 887, -512, e0, e1);
    @(negedge clk);
    check("resume2_y0", y0_o, e0);
    check("resume2_y1", y1_o, e1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
